// File: rtl/reorder_buffer_pkg.sv
// Shared ROB widths and constants for the Tomasulo core.
// Optional flush port is enabled by defining ROB_FLUSH_EN.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH_D  = 8;
  localparam int TAG_WIDTH_D  = 4;
  localparam int REG_WIDTH_D  = 5;
  localparam int DATA_WIDTH_D = 32;
  localparam int ROB_IDX_W_D  = $clog2(ROB_DEPTH_D);
  localparam logic [TAG_WIDTH_D-1:0] TAG_FREE = '1;
endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup by tag: entry array read with same-cycle CDB bypass.
// Tags at or above the depth (including TAG_FREE) never hit.
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH  = ROB_DEPTH_D,
  parameter int TAG_WIDTH  = TAG_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic [TAG_WIDTH-1:0]  qry_tag,
  input  logic [ROB_DEPTH-1:0]  ent_valid,
  input  logic [ROB_DEPTH-1:0]  ent_ready,
  input  logic [DATA_WIDTH-1:0] ent_data [ROB_DEPTH],
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  qry_rdy,
  output logic [DATA_WIDTH-1:0] qry_data
);
  localparam int IDXW = $clog2(ROB_DEPTH);
  localparam logic [TAG_WIDTH-1:0] LIMIT = TAG_WIDTH'(ROB_DEPTH);

  logic [IDXW-1:0] idx;
  logic            hit;
  logic            bypass;

  assign idx    = qry_tag[IDXW-1:0];
  assign hit    = (qry_tag < LIMIT) && ent_valid[idx];
  assign bypass = hit && cdb_valid && (cdb_tag == qry_tag);

  always_comb begin
    qry_rdy  = 1'b0;
    qry_data = '0;
    if (bypass) begin
      qry_rdy  = 1'b1;
      qry_data = cdb_data;
    end else if (hit && ent_ready[idx]) begin
      qry_rdy  = 1'b1;
      qry_data = ent_data[idx];
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: tag allocation, CDB capture, head commit.
// Define ROB_FLUSH_EN to add the flush port.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH  = ROB_DEPTH_D,
  parameter int TAG_WIDTH  = TAG_WIDTH_D,
  parameter int REG_WIDTH  = REG_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ROB_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  alloc_valid,
  input  logic [REG_WIDTH-1:0]  alloc_rd,
  output logic                  alloc_ready,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic [TAG_WIDTH-1:0]  qry_tag1,
  input  logic [TAG_WIDTH-1:0]  qry_tag2,
  output logic                  qry_rdy1,
  output logic                  qry_rdy2,
  output logic [DATA_WIDTH-1:0] qry_data1,
  output logic [DATA_WIDTH-1:0] qry_data2,
  output logic                  commit_en,
  output logic [REG_WIDTH-1:0]  commit_name,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [TAG_WIDTH-1:0]  commit_tag
);
  localparam int IDXW = $clog2(ROB_DEPTH);
  localparam logic [TAG_WIDTH-1:0] LIMIT = TAG_WIDTH'(ROB_DEPTH);
  localparam logic [IDXW:0] FULL = (IDXW+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]  valid;
  logic [ROB_DEPTH-1:0]  ready;
  logic [REG_WIDTH-1:0]  rd   [ROB_DEPTH];
  logic [DATA_WIDTH-1:0] data [ROB_DEPTH];
  logic [IDXW-1:0]       head;
  logic [IDXW-1:0]       tail;
  logic [IDXW:0]         count;

  logic            kill;
  logic            accept;
  logic            retire;
  logic            cdb_hit;
  logic [IDXW-1:0] cdb_idx;

`ifdef ROB_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // alloc_ready looks only at count, so a full ROB refuses even while retiring
  assign alloc_ready = count < FULL;
  assign alloc_tag   = TAG_WIDTH'(tail);
  assign accept      = alloc_valid && alloc_ready;
  assign retire      = valid[head] && ready[head];
  assign cdb_idx     = cdb_tag[IDXW-1:0];
  assign cdb_hit     = cdb_valid && (cdb_tag < LIMIT) && valid[cdb_idx];
  assign commit_en   = retire && (rd[head] != '0) && !kill;

  always_comb begin
    commit_name = '0;
    commit_data = '0;
    commit_tag  = '0;
    if (retire) begin
      commit_name = rd[head];
      commit_data = data[head];
      commit_tag  = TAG_WIDTH'(head);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + IDXW'(1);
      end
      if (cdb_hit) ready[cdb_idx] <= 1'b1;
      if (accept) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + IDXW'(1);
      end
      unique case ({accept, retire})
        2'b10:   count <= count + (IDXW+1)'(1);
        2'b01:   count <= count - (IDXW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cdb_hit) data[cdb_idx] <= cdb_data;
    if (accept) rd[tail] <= alloc_rd;
  end

  rob_query_port #(
    .ROB_DEPTH(ROB_DEPTH), .TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_qry1 (
    .qry_tag(qry_tag1), .ent_valid(valid), .ent_ready(ready),
    .ent_data(data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .qry_rdy(qry_rdy1), .qry_data(qry_data1)
  );

  rob_query_port #(
    .ROB_DEPTH(ROB_DEPTH), .TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_qry2 (
    .qry_tag(qry_tag2), .ent_valid(valid), .ent_ready(ready),
    .ent_data(data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .qry_rdy(qry_rdy2), .qry_data(qry_data2)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus
// randomized traffic against a program-order queue model.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic [3:0]  qry_tag1 = '0;
  logic [3:0]  qry_tag2 = '0;
  logic        qry_rdy1, qry_rdy2;
  logic [31:0] qry_data1, qry_data2;
  logic        commit_en;
  logic [4:0]  commit_name;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .qry_tag1(qry_tag1), .qry_tag2(qry_tag2),
    .qry_rdy1(qry_rdy1), .qry_rdy2(qry_rdy2),
    .qry_data1(qry_data1), .qry_data2(qry_data2),
    .commit_en(commit_en), .commit_name(commit_name),
    .commit_data(commit_data), .commit_tag(commit_tag)
  );

  // Model: outstanding instructions in program order.
  typedef struct {
    int          tag;
    int          rd;
    bit          rdy;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   next_tag = 0;

  function automatic void model_step();
    bit   acc, ret;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      next_tag = 0;
      return;
    end
    acc = alloc_valid && (mq.size() < 8);
    ret = (mq.size() > 0) && mq[0].rdy;
    if (cdb_valid)
      foreach (mq[i])
        if (mq[i].tag == int'(cdb_tag)) begin
          mq[i].rdy  = 1'b1;
          mq[i].data = cdb_data;
        end
    if (ret) void'(mq.pop_front());
    if (acc) begin
      e.tag  = next_tag;
      e.rd   = int'(alloc_rd);
      e.rdy  = 1'b0;
      e.data = '0;
      mq.push_back(e);
      next_tag = (next_tag + 1) % 8;
    end
  endfunction

  function automatic void model_qry(input logic [3:0] t,
                                    output bit r, output logic [31:0] d);
    r = 1'b0;
    d = '0;
    foreach (mq[i])
      if (mq[i].tag == int'(t)) begin
        if (cdb_valid && cdb_tag == t) begin
          r = 1'b1;
          d = cdb_data;
        end else if (mq[i].rdy) begin
          r = 1'b1;
          d = mq[i].data;
        end
      end
  endfunction

  task automatic set_in(input bit av, input logic [4:0] ard,
                        input bit cv, input logic [3:0] ct,
                        input logic [31:0] cd);
    alloc_valid = av;
    alloc_rd    = ard;
    cdb_valid   = cv;
    cdb_tag     = ct;
    cdb_data    = cd;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0);
    qry_tag1 = 0;
    qry_tag2 = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ready got %0b exp 1", alloc_ready); end
    n_cmp++; if (alloc_tag !== 4'd0) begin n_err++; $display("FAIL rst_alloc_tag got %0h exp 0", alloc_tag); end
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL rst_commit_en got %0b exp 0", commit_en); end
    n_cmp++; if (qry_rdy1 !== 1'b0 || qry_rdy2 !== 1'b0) begin n_err++; $display("FAIL rst_qry_rdy got %0b%0b exp 00", qry_rdy1, qry_rdy2); end
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    set_in(1, 3, 0, 0, 0); sample();
    n_cmp++; if (alloc_tag !== 4'd0) begin n_err++; $display("FAIL ord_tag0 got %0h exp 0", alloc_tag); end
    tick();
    set_in(1, 5, 0, 0, 0); sample();
    n_cmp++; if (alloc_tag !== 4'd1) begin n_err++; $display("FAIL ord_tag1 got %0h exp 1", alloc_tag); end
    tick();
    set_in(0, 0, 1, 1, 32'hBB); sample();
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL ord_no_commit_a got %0b exp 0", commit_en); end
    tick();
    set_in(0, 0, 1, 0, 32'hAA); sample();
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL ord_no_comb_path got %0b exp 0", commit_en); end
    tick();
    set_in(0, 0, 0, 0, 0); sample();
    n_cmp++; if ({commit_en, commit_name, commit_data, commit_tag} !== {1'b1, 5'd3, 32'hAA, 4'd0}) begin
      n_err++; $display("FAIL ord_commit0 got %0b/%0d/%0h/%0d exp 1/3/aa/0", commit_en, commit_name, commit_data, commit_tag); end
    tick(); sample();
    n_cmp++; if ({commit_en, commit_name, commit_data, commit_tag} !== {1'b1, 5'd5, 32'hBB, 4'd1}) begin
      n_err++; $display("FAIL ord_commit1 got %0b/%0d/%0h/%0d exp 1/5/bb/1", commit_en, commit_name, commit_data, commit_tag); end
    tick(); sample();
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL ord_drained got %0b exp 0", commit_en); end
    tick();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 5'(i + 1), 0, 0, 0);
      tick();
    end
    set_in(1, 7, 0, 0, 0); sample();
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0b exp 0", alloc_ready); end
    tick();
    set_in(0, 0, 1, 0, 32'h10); sample();
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_9th_ignored got %0b exp 0", alloc_ready); end
    tick();
    set_in(0, 0, 0, 0, 0); sample();
    n_cmp++; if (commit_en !== 1'b1 || commit_name !== 5'd1) begin n_err++; $display("FAIL full_head_commit got %0b/%0d exp 1/1", commit_en, commit_name); end
    tick(); sample();
    n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin n_err++; $display("FAIL wrap_tag got %0b/%0h exp 1/0", alloc_ready, alloc_tag); end
    set_in(1, 9, 0, 0, 0);
    tick(); set_in(0, 0, 0, 0, 0); sample();
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL wrap_refull got %0b exp 0", alloc_ready); end
    tick();
  endtask

  task automatic test_full_alloc_retire();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 5'(i + 10), 0, 0, 0);
      tick();
    end
    set_in(0, 0, 1, 0, 32'h77);
    tick();
    set_in(1, 20, 0, 0, 0); sample();
    n_cmp++; if (commit_en !== 1'b1 || alloc_ready !== 1'b0) begin n_err++; $display("FAIL fr_same_cycle got en %0b rdy %0b exp 1/0", commit_en, alloc_ready); end
    tick(); sample();
    n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0 || commit_en !== 1'b0) begin
      n_err++; $display("FAIL fr_next_cycle got rdy %0b tag %0h en %0b exp 1/0/0", alloc_ready, alloc_tag, commit_en); end
    tick(); set_in(0, 0, 0, 0, 0); sample();
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fr_accepted got %0b exp 0", alloc_ready); end
    tick();
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 6, 0, 0, 0); tick();
    set_in(0, 0, 1, 0, 32'h1); tick();
    set_in(0, 0, 1, 1, 32'h22); qry_tag1 = 0; sample();
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL rd0_silent got %0b exp 0", commit_en); end
    n_cmp++; if (qry_rdy1 !== 1'b1 || qry_data1 !== 32'h1) begin n_err++; $display("FAIL rd0_qry got %0b/%0h exp 1/1", qry_rdy1, qry_data1); end
    tick();
    set_in(0, 0, 0, 0, 0); sample();
    n_cmp++; if ({commit_en, commit_name, commit_data, commit_tag} !== {1'b1, 5'd6, 32'h22, 4'd1}) begin
      n_err++; $display("FAIL rd0_next got %0b/%0d/%0h/%0d exp 1/6/22/1", commit_en, commit_name, commit_data, commit_tag); end
    tick();
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(i + 1), 0, 0, 0);
      tick();
    end
    set_in(0, 0, 1, 2, 32'h55);
    qry_tag1 = 2;
    qry_tag2 = 4'hF;
    sample();
    n_cmp++; if (qry_rdy1 !== 1'b1 || qry_data1 !== 32'h55) begin n_err++; $display("FAIL qry_bypass got %0b/%0h exp 1/55", qry_rdy1, qry_data1); end
    n_cmp++; if (qry_rdy2 !== 1'b0 || qry_data2 !== 32'h0) begin n_err++; $display("FAIL qry_tagfree got %0b/%0h exp 0/0", qry_rdy2, qry_data2); end
    qry_tag2 = 1; #1;
    n_cmp++; if (qry_rdy2 !== 1'b0 || qry_data2 !== 32'h0) begin n_err++; $display("FAIL qry_not_ready got %0b/%0h exp 0/0", qry_rdy2, qry_data2); end
    tick();
    set_in(0, 0, 0, 0, 0);
    qry_tag2 = 5;
    sample();
    n_cmp++; if (qry_rdy1 !== 1'b1 || qry_data1 !== 32'h55) begin n_err++; $display("FAIL qry_stored got %0b/%0h exp 1/55", qry_rdy1, qry_data1); end
    n_cmp++; if (qry_rdy2 !== 1'b0) begin n_err++; $display("FAIL qry_invalid got %0b exp 0", qry_rdy2); end
    tick();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(i + 1), 0, 0, 0);
      tick();
    end
    set_in(0, 0, 1, 0, 32'h5); tick();
    set_in(0, 0, 1, 1, 32'h6); tick();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qry_tag1 = 0;
    sample();
    n_cmp++; if (commit_en !== 1'b0 || alloc_tag !== 4'd0 || alloc_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_state got en %0b tag %0h rdy %0b exp 0/0/1", commit_en, alloc_tag, alloc_ready); end
    n_cmp++; if (qry_rdy1 !== 1'b0) begin n_err++; $display("FAIL midrst_qry got %0b exp 0", qry_rdy1); end
    for (int i = 0; i < 7; i++) begin
      set_in(1, 5'(i + 1), 0, 0, 0);
      tick();
    end
    sample();
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL midrst_count7 got %0b exp 1", alloc_ready); end
    tick(); set_in(0, 0, 0, 0, 0); sample();
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL midrst_count8 got %0b exp 0", alloc_ready); end
    tick();
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(i + 1), 0, 0, 0);
      tick();
    end
    set_in(0, 0, 1, 0, 32'h9); tick();
    set_in(0, 0, 1, 1, 32'hA); tick();
    set_in(1, 7, 0, 0, 0);
    flush = 1'b1;
    sample();
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL flush_gate got %0b exp 0", commit_en); end
    tick();
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0);
    sample();
    n_cmp++; if (commit_en !== 1'b0 || alloc_tag !== 4'd0 || alloc_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_state got en %0b tag %0h rdy %0b exp 0/0/1", commit_en, alloc_tag, alloc_ready); end
    tick();
  endtask
`endif

  task automatic test_random();
    int          pend[$];
    bit          er, r1, r2;
    logic [4:0]  en_name;
    logic [31:0] e_data, d1, d2;
    logic [3:0]  e_tag;
    bit          e_en;
    int          bias;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bias = ((c / 100) % 2 == 0) ? 75 : 35;
      pend.delete();
      foreach (mq[i]) if (!mq[i].rdy) pend.push_back(mq[i].tag);
      alloc_valid = ($urandom_range(99) < bias);
      alloc_rd    = 5'($urandom_range(31));
      cdb_valid   = ($urandom_range(99) < 60);
      if (pend.size() > 0 && $urandom_range(99) < 80)
        cdb_tag = 4'(pend[$urandom_range(pend.size() - 1)]);
      else
        cdb_tag = 4'($urandom_range(15));
      cdb_data = $urandom;
      qry_tag1 = (mq.size() > 0 && $urandom_range(1) == 1) ?
                 4'(mq[$urandom_range(mq.size() - 1)].tag) : 4'($urandom_range(15));
      qry_tag2 = 4'($urandom_range(15));
      er = (mq.size() > 0) && mq[0].rdy;
      e_en = 1'b0; en_name = '0; e_data = '0; e_tag = '0;
      if (er) begin
        en_name = 5'(mq[0].rd);
        e_data  = mq[0].data;
        e_tag   = 4'(mq[0].tag);
        e_en    = (mq[0].rd != 0);
      end
      model_qry(qry_tag1, r1, d1);
      model_qry(qry_tag2, r2, d2);
      sample();
      n_cmp++; if (alloc_ready !== (mq.size() < 8) || alloc_tag !== 4'(next_tag)) begin
        n_err++; $display("FAIL rnd_alloc c%0d got %0b/%0h exp %0b/%0h", c, alloc_ready, alloc_tag, mq.size() < 8, next_tag); end
      n_cmp++; if ({commit_en, commit_name, commit_data, commit_tag} !== {e_en, en_name, e_data, e_tag}) begin
        n_err++; $display("FAIL rnd_commit c%0d got %0b/%0d/%0h/%0d exp %0b/%0d/%0h/%0d", c,
          commit_en, commit_name, commit_data, commit_tag, e_en, en_name, e_data, e_tag); end
      n_cmp++; if (qry_rdy1 !== r1 || qry_data1 !== d1) begin
        n_err++; $display("FAIL rnd_qry1 c%0d tag %0h got %0b/%0h exp %0b/%0h", c, qry_tag1, qry_rdy1, qry_data1, r1, d1); end
      n_cmp++; if (qry_rdy2 !== r2 || qry_data2 !== d2) begin
        n_err++; $display("FAIL rnd_qry2 c%0d tag %0h got %0b/%0h exp %0b/%0h", c, qry_tag2, qry_rdy2, qry_data2, r2, d2); end
      tick();
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_full_alloc_retire();
    test_rd_zero();
    test_query_bypass();
    test_reset_midrun();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
